// File: rtl/mux2a1_sched_l2_pkg.sv
// Shared types and widths for the second-level 2:1 byte lane scheduler.
package sched_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned BURST_W = 4;
    localparam int unsigned STAT_W  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE0 = 2'd1,
        SERVE1 = 2'd2
    } sched_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/mux2a1_sched_l2_if.sv
// Lane request / downstream bus of the 2:1 scheduler.
// Optional SCHED_STATS_EN adds the count0/count1 statistics signals.
interface mux2a1_sched_l2_if;
    import sched_pkg::*;

    logic              valid0;
    logic              valid1;
    logic [DATA_W-1:0] data_in0;
    logic [DATA_W-1:0] data_in1;
    logic              ready_out;
    logic              ready0;
    logic              ready1;
    logic              selector;
    logic              validout;
    logic [DATA_W-1:0] dataout;
`ifdef SCHED_STATS_EN
    logic [STAT_W-1:0] count0;
    logic [STAT_W-1:0] count1;
`endif

    // Requester lanes plus downstream sink.
    modport master (
        output valid0, valid1, data_in0, data_in1, ready_out,
        input  ready0, ready1, selector, validout, dataout
`ifdef SCHED_STATS_EN
        , input count0, count1
`endif
    );

    // Scheduler side.
    modport slave (
        input  valid0, valid1, data_in0, data_in1, ready_out,
        output ready0, ready1, selector, validout, dataout
`ifdef SCHED_STATS_EN
        , output count0, count1
`endif
    );

endinterface

// File: rtl/mux2a1_sched_rr_core.sv
// Round-robin grant FSM with per-lane burst limit; owns last pointer and burst count.
module mux2a1_sched_rr_core
    import sched_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_can_accept,
    output logic o_ready0_c,
    output logic o_ready1_c,
    output logic o_selector
);

    sched_state_e       r_state;
    sched_state_e       w_state_nxt;
    logic               r_last;
    logic               w_last_nxt;
    logic [BURST_W-1:0] r_burst;
    logic [BURST_W-1:0] w_burst_nxt;
    logic [BURST_W-1:0] w_burst_sum;
    logic               r_selector;
    logic               w_serve1;
    logic               w_own_v;
    logic               w_oth_v;
    logic               w_xfer;
    sched_state_e       w_other_state;

    // Grants only in a SERVE state, and only when the output stage can take a byte.
    assign o_ready0_c = (r_state == SERVE0) && i_valid0 && i_can_accept;
    assign o_ready1_c = (r_state == SERVE1) && i_valid1 && i_can_accept;
    assign o_selector = r_selector;

    assign w_serve1      = (r_state == SERVE1);
    assign w_own_v       = w_serve1 ? i_valid1 : i_valid0;
    assign w_oth_v       = w_serve1 ? i_valid0 : i_valid1;
    assign w_xfer        = o_ready0_c | o_ready1_c;
    assign w_burst_sum   = r_burst + BURST_W'(w_xfer);
    assign w_other_state = w_serve1 ? SERVE0 : SERVE1;

    // Next-state: tie-break on last, yield on drain or end-of-burst.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_burst_nxt = r_burst;
        unique case (r_state)
            IDLE: begin
                if (i_valid0 && i_valid1) begin
                    w_state_nxt = r_last ? SERVE0 : SERVE1;
                end else if (i_valid0) begin
                    w_state_nxt = SERVE0;
                end else if (i_valid1) begin
                    w_state_nxt = SERVE1;
                end
            end
            SERVE0, SERVE1: begin
                if (!w_own_v) begin
                    w_burst_nxt = '0;
                    w_last_nxt  = w_serve1;
                    w_state_nxt = w_oth_v ? w_other_state : IDLE;
                end else if (w_burst_sum == BURST_W'(MAX_BURST)) begin
                    w_burst_nxt = '0;
                    if (w_oth_v) begin
                        w_last_nxt  = w_serve1;
                        w_state_nxt = w_other_state;
                    end
                end else begin
                    w_burst_nxt = w_burst_sum;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_burst_nxt = '0;
            end
        endcase
    end

    // State, history and registered selector.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_last     <= 1'b1;
            r_burst    <= '0;
            r_selector <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_last     <= w_last_nxt;
            r_burst    <= w_burst_nxt;
            r_selector <= (w_state_nxt == SERVE1);
        end
    end

endmodule

// File: rtl/mux2a1_sched_l2.sv
// Second-level 2:1 byte lane scheduler: rr core, data mux and registered output stage.
// Optional SCHED_STATS_EN adds saturating per-lane transfer counters.
module mux2a1_sched_l2
    import sched_pkg::*;
#(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                 clk_4f,
    input  logic                 reset,
    mux2a1_sched_l2_if.slave     bus
);

    logic              w_can_accept;
    logic              w_ready0;
    logic              w_ready1;
    logic              w_selector;
    logic              w_xfer;
    logic [DATA_W-1:0] w_data_sel;
    logic              r_validout;
    logic [DATA_W-1:0] r_dataout;

    assign w_can_accept = !r_validout || bus.ready_out;

    mux2a1_sched_rr_core #(
        .MAX_BURST (MAX_BURST)
    ) u_core (
        .i_clk        (clk_4f),
        .i_rst        (reset),
        .i_valid0     (bus.valid0),
        .i_valid1     (bus.valid1),
        .i_can_accept (w_can_accept),
        .o_ready0_c   (w_ready0),
        .o_ready1_c   (w_ready1),
        .o_selector   (w_selector)
    );

    // Grants are one-hot, so the byte comes from whichever lane is popped.
    assign w_xfer     = w_ready0 | w_ready1;
    assign w_data_sel = w_ready1 ? bus.data_in1 : bus.data_in0;

    assign bus.ready0   = w_ready0;
    assign bus.ready1   = w_ready1;
    assign bus.selector = w_selector;
    assign bus.validout = r_validout;
    assign bus.dataout  = r_dataout;

    // Output register: load on pop, empty when drained with nothing new.
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            r_validout <= 1'b0;
            r_dataout  <= '0;
        end else if (w_xfer) begin
            r_validout <= 1'b1;
            r_dataout  <= w_data_sel;
        end else if (bus.ready_out) begin
            r_validout <= 1'b0;
        end
    end

`ifdef SCHED_STATS_EN
    logic [STAT_W-1:0] r_count0;
    logic [STAT_W-1:0] r_count1;

    assign bus.count0 = r_count0;
    assign bus.count1 = r_count1;

    // Saturating accepted-transfer counters per lane.
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            r_count0 <= '0;
            r_count1 <= '0;
        end else begin
            if (w_ready0) r_count0 <= sat_inc(r_count0);
            if (w_ready1) r_count1 <= sat_inc(r_count1);
        end
    end
`endif

endmodule
